uart_num_asc_tx: RTL and testbench
==================================

Name: uart_num_asc_tx

Overview:
Reverse path of the coordinate receive chain. Takes three 32-bit unsigned coordinates (x, y, z), converts each to unsigned decimal ASCII, and streams the frame byte by byte into the uarttx transmitter through its datain/wrsig/idle handshake. Frame format is digits "," digits "," digits CR LF, with leading zeros suppressed. It sits between the coordinate registers and uarttx, on the divided uart clock.

Parameters:
HOLDOFF, 2, cycles to wait after a tx_wr pulse before tx_idle is sampled (covers uarttx busy-flag latency).
EOL_CRLF, 1, 1 = end the frame with CR LF (0x0D 0x0A); 0 = LF only.

Ports:
clk  in  1  uart-domain clock (clkdiv output)
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle request; x/y/z are sampled on this cycle
clr  in  1  synchronous abort; return to idle
x  in  32  x coordinate, unsigned
y  in  32  y coordinate, unsigned
z  in  32  z coordinate, unsigned
busy  out  1  high from the cycle after an accepted start until done or abort
done  out  1  one-cycle pulse after the final byte is accepted by uarttx
tx_data  out  8  byte to uarttx datain
tx_wr  out  1  one-cycle write strobe to uarttx wrsig
tx_idle  in  1  uarttx idle flag; high = ready for a byte

Behaviour:
- Reset (async, rst=1): busy=0, done=0, tx_wr=0, tx_data=0x00, state IDLE, latched coordinates cleared.
- Start acceptance: start is accepted only in IDLE with clr=0. x, y and z are latched on that cycle. A start while busy is ignored, with no effect on the current frame.
- States: IDLE -> CONV -> SCAN -> EMIT -> WAIT -> (EMIT | CONV | DONE) -> IDLE.
- CONV: bin2bcd_seq converts the current latched value (sel = 0, 1, 2 for x, y, z) into 10 BCD digits. It takes exactly 32 shift cycles plus 1 done cycle.
- SCAN: examines digits from index 9 down to 0 at one digit per cycle and stops at the first nonzero digit. If all digits are zero, it emits a single '0'. Digit 0 is always emitted.
- EMIT: drives tx_data = 0x30 + digit for each digit, then the separator. The separator is ',' (0x2C) after x and y. After z it is CR then LF, or LF only when EOL_CRLF=0. tx_wr is high for exactly one cycle per byte, and tx_data is stable from that cycle until the next tx_wr.
- WAIT: waits HOLDOFF cycles, then waits for tx_idle=1. A tx_idle held low stalls the frame indefinitely, with no further tx_wr.
- Byte issue timing: EMIT issues a byte only in a cycle where tx_idle=1 (sampled after holdoff). No tx_wr is issued while tx_idle=0.
- Frame length: 7 bytes minimum ("0,0,0\r\n"), 34 bytes maximum.
- First-byte latency: the first tx_wr of the frame occurs at most 45 cycles after start when tx_idle=1.
- Completion: after the last byte's WAIT completes, done pulses for 1 cycle, busy falls in the same cycle, and the block returns to IDLE. start is accepted again on the next cycle.
- clr: takes priority over everything except rst. On clr, in any state: tx_wr=0, busy=0, no done pulse, converter reset, IDLE on the next cycle. tx_data keeps its last value.
- Reset mid-frame: everything returns to reset values immediately, and nothing further is sent.
- Arithmetic: double-dabble uses a 40-bit BCD register with add-3 when a nibble is >= 5, applied before each shift. All 32-bit values 0..4294967295 are exact.

Decomposition:
- Shared package uart_pkg holds:
  - ASCII constants: ASC_0=0x30, ASC_COMMA=0x2C, ASC_CR=0x0D, ASC_LF=0x0A.
  - State enumeration for this block.
  - NUM_DIGITS=10.
- Sub-module bin2bcd_seq holds the sequential 32-bit to 10-digit BCD converter.
  - Ports: clk, rst, start, bin[31:0], bcd[39:0], done.
  - Latency: 33 cycles.

Test Plan:
- x=0, y=0, z=0, tx_idle always 1 -> bytes 30 2C 30 2C 30 0D 0A, then one done pulse, busy low.
- x=123, y=45, z=6 -> "123,45,6\r\n" = 31 32 33 2C 34 35 2C 36 0D 0A; no leading 0x30 bytes.
- x=4294967295, y=1000000000, z=10 -> "4294967295,1000000000,10\r\n" (26 bytes); interior zeros are preserved.
- Model uarttx busy for 1000 cycles per byte (idle drops 1 cycle after wrsig) -> exactly one tx_wr per byte, never while idle=0. A second start mid-frame is ignored and the frame is unchanged.
- clr asserted after the 5th byte -> no further tx_wr, no done, busy=0 next cycle. A new start then sends a complete fresh frame.
- rst pulsed mid-conversion -> all outputs at reset values immediately. tx_idle held 0 after a start -> the frame stalls after the first tx_wr, with busy held 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, state encodings and the BCD adjust helper for the
// coordinate-to-ASCII transmit path.
package uart_pkg;

    localparam int NUM_DIGITS = 10;
    localparam int BCD_W      = 4 * NUM_DIGITS;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_COMMA = 8'h2C;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_SCAN,
        ST_EMIT,
        ST_WAIT,
        ST_DONE
    } tx_state_e;

    // Which kind of byte the emit pointer currently refers to.
    typedef enum logic [1:0] {
        PH_DIG,
        PH_SEP,
        PH_LF
    } emit_phase_e;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 32-bit binary to 10-digit BCD converter (double-dabble).
// A start pulse loads the operand; 32 shift cycles follow and done pulses
// on the 33rd cycle after start. bcd holds its value until the next start.
module bin2bcd_seq
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done
);

    logic [31:0]      sh_q,  sh_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [BCD_W-1:0] adj;

    // Load on start (a new start always wins), otherwise adjust-then-shift while the counter runs.
    always_comb begin
        sh_d   = sh_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        adj    = bcd_add3(bcd_q);
        if (start) begin
            sh_d  = bin;
            bcd_d = '0;
            cnt_d = 6'd32;
        end else if (cnt_q != 6'd0) begin
            {bcd_d, sh_d} = {adj, sh_q} << 1;
            cnt_d         = cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
                done_d = 1'b1;
            end
        end
    end

    // Converter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bcd  = bcd_q;
    assign done = done_q;

endmodule

// File: rtl/uart_num_asc_tx.sv
// Streams x,y,z as unsigned decimal ASCII ("x,y,z" CR LF, no leading zeros)
// into uarttx through its datain/wrsig/idle handshake.
//
// state | meaning
// IDLE  | waiting for start; coordinates latched on acceptance
// CONV  | bin2bcd_seq converting coordinate sel
// SCAN  | skipping leading zero digits, 9 down to 0
// EMIT  | waiting for tx_idle, then issuing one byte
// WAIT  | holdoff countdown, then waiting for tx_idle
// DONE  | one-cycle done pulse, back to IDLE
module uart_num_asc_tx
    import uart_pkg::*;
#(
    parameter int unsigned HOLDOFF  = 2,
    parameter bit          EOL_CRLF = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        clr,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [31:0] z,
    output logic        busy,
    output logic        done,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_idle
);

    localparam int HOLD_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLDOFF);

    tx_state_e         state_q, state_d;
    emit_phase_e       phase_q, phase_d;
    logic [31:0]       x_q, x_d, y_q, y_d, z_q, z_d;
    logic [1:0]        sel_q, sel_d, sel_nx;
    logic [3:0]        dig_q, dig_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_wr_q, tx_wr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              conv_start;
    logic [31:0]       conv_bin;
    logic [BCD_W-1:0]  conv_bcd;
    logic              conv_done;
    logic [3:0]        cur_digit;
    logic              scan_stop;
    logic              wait_over;
    logic              last_coord;
    logic [7:0]        emit_byte;
    logic [31:0]       next_coord;

    // Aborted conversions are simply discarded: each conversion begins with a
    // fresh load, so the converter never carries state from one run to the next.
    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (conv_bin),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    // Shared decode used by both the next-state and output logic.
    always_comb begin
        cur_digit  = conv_bcd[{dig_q, 2'b00} +: 4];
        scan_stop  = (cur_digit != 4'd0) || (dig_q == 4'd0);
        wait_over  = (hold_q == '0) && tx_idle;
        last_coord = (sel_q == 2'd2);
        sel_nx     = sel_q + 2'd1;
        case (sel_nx)
            2'd0:    next_coord = x_q;
            2'd1:    next_coord = y_q;
            default: next_coord = z_q;
        endcase
        case (phase_q)
            PH_DIG:  emit_byte = ASC_0 + {4'b0000, cur_digit};
            PH_SEP:  emit_byte = !last_coord ? ASC_COMMA : (EOL_CRLF ? ASC_CR : ASC_LF);
            default: emit_byte = ASC_LF;
        endcase
    end

    // Next-state logic; clr forces IDLE from any state.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start) state_d = ST_CONV;
                ST_CONV: if (conv_done) state_d = ST_SCAN;
                ST_SCAN: if (scan_stop) state_d = ST_EMIT;
                ST_EMIT: if (tx_idle) state_d = ST_WAIT;
                ST_WAIT: begin
                    if (wait_over) begin
                        case (phase_q)
                            PH_DIG:  state_d = ST_EMIT;
                            PH_SEP:  state_d = !last_coord ? ST_CONV :
                                               (EOL_CRLF ? ST_EMIT : ST_DONE);
                            default: state_d = ST_DONE;
                        endcase
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath and output register updates for each state.
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        z_d        = z_q;
        sel_d      = sel_q;
        dig_d      = dig_q;
        phase_d    = phase_q;
        hold_d     = hold_q;
        tx_data_d  = tx_data_q;
        tx_wr_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        conv_start = 1'b0;
        conv_bin   = next_coord;
        if (clr) begin
            busy_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        x_d        = x;
                        y_d        = y;
                        z_d        = z;
                        sel_d      = 2'd0;
                        busy_d     = 1'b1;
                        conv_start = 1'b1;
                        conv_bin   = x;
                    end
                end
                ST_CONV: begin
                    if (conv_done) begin
                        dig_d   = 4'd9;
                        phase_d = PH_DIG;
                    end
                end
                ST_SCAN: begin
                    if (!scan_stop) begin
                        dig_d = dig_q - 4'd1;
                    end
                end
                ST_EMIT: begin
                    if (tx_idle) begin
                        tx_wr_d   = 1'b1;
                        tx_data_d = emit_byte;
                        hold_d    = HOLD_INIT;
                    end
                end
                ST_WAIT: begin
                    if (hold_q != '0) begin
                        hold_d = hold_q - HOLD_W'(1);
                    end else if (tx_idle) begin
                        case (phase_q)
                            PH_DIG: begin
                                if (dig_q != 4'd0) dig_d   = dig_q - 4'd1;
                                else               phase_d = PH_SEP;
                            end
                            PH_SEP: begin
                                if (!last_coord) begin
                                    sel_d      = sel_nx;
                                    conv_start = 1'b1;
                                end else if (EOL_CRLF) begin
                                    phase_d = PH_LF;
                                end else begin
                                    done_d = 1'b1;
                                    busy_d = 1'b0;
                                end
                            end
                            default: begin
                                done_d = 1'b1;
                                busy_d = 1'b0;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            phase_q   <= PH_DIG;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            sel_q     <= '0;
            dig_q     <= '0;
            hold_q    <= '0;
            tx_data_q <= 8'h00;
            tx_wr_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            sel_q     <= sel_d;
            dig_q     <= dig_d;
            hold_q    <= hold_d;
            tx_data_q <= tx_data_d;
            tx_wr_q   <= tx_wr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign tx_data = tx_data_q;
    assign tx_wr   = tx_wr_q;

endmodule

// File: tb/tb_uart_num_asc_tx.sv
// Bench for uart_num_asc_tx: expected bytes are queued at stimulus time, a
// monitor with a small uarttx busy model pops and compares on every tx_wr.
module tb_uart_num_asc_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        clr;
    logic [31:0] x, y, z;
    logic        busy, done, tx_wr;
    logic [7:0]  tx_data;
    logic        tx_idle = 1'b1;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    int exp_done_pend = 0;
    int done_seen = 0;
    int wr_total = 0;
    int busy_len = 0;
    int idle_cnt = 0;
    logic prev_wr = 1'b0;

    uart_num_asc_tx #(.HOLDOFF(2), .EOL_CRLF(1'b1)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .clr     (clr),
        .x       (x),
        .y       (y),
        .z       (z),
        .busy    (busy),
        .done    (done),
        .tx_data (tx_data),
        .tx_wr   (tx_wr),
        .tx_idle (tx_idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic push_eol();
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        @(negedge clk);
        x = a; y = b; z = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int limit, input string name);
        int n;
        n = 0;
        while (done_seen < target && n < limit) begin
            @(posedge clk);
            n++;
        end
        check(name, {31'b0, done_seen >= target}, 32'd1);
    endtask

    task automatic wait_wr(input int target, input int limit, input string name);
        int n;
        n = 0;
        while (wr_total < target && n < limit) begin
            @(posedge clk);
            n++;
        end
        check(name, {31'b0, wr_total >= target}, 32'd1);
    endtask

    // Scoreboard monitor followed by the uarttx idle model (idle low busy_len cycles per byte).
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst) begin
            if (tx_wr) begin
                wr_total++;
                check("wr_needs_idle", {31'b0, tx_idle}, 32'd1);
                check("wr_one_cycle", {31'b0, prev_wr}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte: got %0h expected none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", {24'b0, tx_data}, {24'b0, e});
                end
            end
            if (done) begin
                done_seen++;
                if (exp_done_pend == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got 1 expected 0");
                end else begin
                    exp_done_pend--;
                    check("bytes_left_at_done", exp_q.size(), 32'd0);
                    check("busy_at_done", {31'b0, busy}, 32'd0);
                end
            end
        end
        prev_wr = tx_wr;
        if (tx_wr && !rst) idle_cnt = busy_len;
        else if (idle_cnt > 0) idle_cnt--;
        tx_idle = (idle_cnt == 0);
    end

    initial begin
        int lat;
        int w0;
        int d0;
        rst = 1'b1; start = 1'b0; clr = 1'b0; x = '0; y = '0; z = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_tx_wr", {31'b0, tx_wr}, 32'd0);
        check("rst_tx_data", {24'b0, tx_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // all zeros, with first-byte latency measurement
        push_str("0,0,0"); push_eol(); exp_done_pend++;
        @(negedge clk);
        x = 0; y = 0; z = 0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'b0, busy}, 32'd1);
        lat = 1;
        while (tx_wr !== 1'b1 && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("first_byte_latency_le45", {31'b0, lat <= 45}, 32'd1);
        wait_done(1, 500, "t1_done");
        @(negedge clk);
        check("t1_busy_low", {31'b0, busy}, 32'd0);

        push_str("123,45,6"); push_eol(); exp_done_pend++;
        send(123, 45, 6);
        wait_done(2, 1000, "t2_done");

        push_str("4294967295,1000000000,10"); push_eol(); exp_done_pend++;
        send(32'hFFFF_FFFF, 1000000000, 10);
        wait_done(3, 2000, "t3_done");

        // slow uarttx, plus an ignored start mid-frame
        busy_len = 1000;
        w0 = wr_total;
        push_str("7,8,9"); push_eol(); exp_done_pend++;
        send(7, 8, 9);
        wait_wr(w0 + 2, 5000, "t4_two_bytes");
        @(negedge clk);
        x = 55; y = 66; z = 77; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(4, 20000, "t4_done");
        check("t4_wr_count", wr_total - w0, 32'd7);
        busy_len = 0;
        repeat (5) @(posedge clk);

        // abort after the fifth byte
        w0 = wr_total;
        d0 = done_seen;
        push_str("12,34");
        send(12, 34, 5);
        wait_wr(w0 + 5, 1000, "t5_five_bytes");
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t5_busy_after_clr", {31'b0, busy}, 32'd0);
        repeat (150) @(posedge clk);
        check("t5_wr_count", wr_total - w0, 32'd5);
        check("t5_no_done", done_seen - d0, 32'd0);
        push_str("1,2,3"); push_eol(); exp_done_pend++;
        send(1, 2, 3);
        wait_done(d0 + 1, 1000, "t5_fresh_done");

        // async reset mid-conversion
        w0 = wr_total;
        send(77, 88, 99);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_busy", {31'b0, busy}, 32'd0);
        check("t6_done", {31'b0, done}, 32'd0);
        check("t6_tx_wr", {31'b0, tx_wr}, 32'd0);
        check("t6_tx_data", {24'b0, tx_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (150) @(posedge clk);
        check("t6_no_bytes", wr_total - w0, 32'd0);

        // tx_idle stuck low after the first byte
        busy_len = 1000000;
        w0 = wr_total;
        d0 = done_seen;
        push_str("5");
        send(5, 6, 7);
        repeat (300) @(posedge clk);
        @(negedge clk);
        check("t7_wr_count", wr_total - w0, 32'd1);
        check("t7_busy_held", {31'b0, busy}, 32'd1);
        check("t7_no_done", done_seen - d0, 32'd0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t7_busy_after_clr", {31'b0, busy}, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
